// File: rtl/instr_enc_pkg.sv
// Shared definitions for the instruction encoder/writer: format codes, FSM states,
// big-endian [0:31] field positions and the field-packing function.
package instr_enc_pkg;

  typedef enum logic [1:0] {
    FMT_R   = 2'd0,
    FMT_I   = 2'd1,
    FMT_J   = 2'd2,
    FMT_RSV = 2'd3
  } fmt_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  // Bit 0 is the MSB of the word, matching the decoder's layout.
  typedef logic [0:31] word_t;

  localparam int OPC_MSB   = 0;
  localparam int OPC_LSB   = 4;
  localparam int RS_MSB    = 5;
  localparam int RS_LSB    = 9;
  localparam int RT_MSB    = 10;
  localparam int RT_LSB    = 14;
  localparam int RD_MSB    = 15;
  localparam int RD_LSB    = 19;
  localparam int FUNCT_MSB = 20;
  localparam int FUNCT_LSB = 31;
  localparam int IMM_MSB   = 15;
  localparam int IMM_LSB   = 31;
  localparam int TGT_MSB   = 5;
  localparam int TGT_LSB   = 31;

  function automatic word_t pack_word(
    input fmt_e        fmt,
    input logic [4:0]  opcode,
    input logic [4:0]  rs,
    input logic [4:0]  rt,
    input logic [4:0]  rd,
    input logic [11:0] funct,
    input logic [16:0] imm,
    input logic [26:0] target
  );
    word_t w;
    w = '0;
    w[OPC_MSB:OPC_LSB] = opcode;
    case (fmt)
      FMT_I: begin
        w[RS_MSB:RS_LSB]   = rs;
        w[RT_MSB:RT_LSB]   = rt;
        w[IMM_MSB:IMM_LSB] = imm;
      end
      FMT_J: begin
        w[TGT_MSB:TGT_LSB] = target;
      end
      default: begin
        // Reserved format shares the R-type layout.
        w[RS_MSB:RS_LSB]       = rs;
        w[RT_MSB:RT_LSB]       = rt;
        w[RD_MSB:RD_LSB]       = rd;
        w[FUNCT_MSB:FUNCT_LSB] = funct;
      end
    endcase
    return w;
  endfunction

endpackage

// File: rtl/instr_enc_fifo.sv
// Show-ahead synchronous FIFO for encoded words; head entry is visible on rdata_o
// whenever empty_o is low.
module instr_enc_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push_i,
  input  logic [W-1:0] wdata_i,
  input  logic         pop_i,
  output logic [W-1:0] rdata_o,
  output logic         full_o,
  output logic         empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem_q [DEPTH];
  logic [AW:0]  wr_ptr_q, wr_ptr_d;
  logic [AW:0]  rd_ptr_q, rd_ptr_d;
  logic         do_push, do_pop;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign rdata_o = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

endmodule

// File: rtl/instr_encoder_writer.sv
// Packs instruction field bundles into words and streams them to instruction memory.
// Optional macro INSTR_ENC_CHECK_EN: drops reserved-format bundles and flags them on err.
module instr_encoder_writer
  import instr_enc_pkg::*;
#(
  parameter int ADDR_W     = 10,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_last,
  input  logic [1:0]        in_fmt,
  input  logic [4:0]        in_opcode,
  input  logic [4:0]        in_rs,
  input  logic [4:0]        in_rt,
  input  logic [4:0]        in_rd,
  input  logic [11:0]       in_funct,
  input  logic [16:0]       in_imm,
  input  logic [26:0]       in_target,
  output logic              mem_wr_en,
  input  logic              mem_wr_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              busy,
  output logic              done,
`ifdef INSTR_ENC_CHECK_EN
  output logic              err,
`endif
  output logic [ADDR_W:0]   words_written
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W:0]   cnt_q, cnt_d;
  logic              accept, push, wr_hs;
  logic              fifo_full, fifo_empty;
  logic [31:0]       fifo_rdata;
  word_t             packed_w;

  assign packed_w = pack_word(fmt_e'(in_fmt), in_opcode, in_rs, in_rt, in_rd,
                              in_funct, in_imm, in_target);

  assign in_ready  = (state_q == ST_RUN) && !fifo_full;
  assign accept    = in_valid && in_ready;
  assign mem_wr_en = !fifo_empty && ((state_q == ST_RUN) || (state_q == ST_DRAIN));
  assign wr_hs     = mem_wr_en && mem_wr_ready;
  assign busy      = (state_q != ST_IDLE);
  assign done      = (state_q == ST_DONE);
  assign mem_addr  = addr_q;
  assign words_written = cnt_q;
  // Gated so the uninitialised buffer never shows on the bus.
  assign mem_wdata = mem_wr_en ? fifo_rdata : 32'd0;

`ifdef INSTR_ENC_CHECK_EN
  logic err_q, err_d;
  assign err  = err_q;
  assign push = accept && (fmt_e'(in_fmt) != FMT_RSV);
`else
  assign push = accept;
`endif

  instr_enc_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (32)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push),
    .wdata_i (packed_w),
    .pop_i   (wr_hs),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
`ifdef INSTR_ENC_CHECK_EN
    err_d   = err_q;
    if (accept && (fmt_e'(in_fmt) == FMT_RSV)) err_d = 1'b1;
`endif
    if (wr_hs) begin
      addr_d = addr_q + ADDR_W'(1);
      cnt_d  = (&cnt_q) ? cnt_q : cnt_q + (ADDR_W + 1)'(1);
    end
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_RUN;
          addr_d  = base_addr;
          cnt_d   = '0;
`ifdef INSTR_ENC_CHECK_EN
          err_d   = 1'b0;
`endif
        end
      end
      ST_RUN:   if (accept && in_last) state_d = ST_DRAIN;
      ST_DRAIN: if (fifo_empty) state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      cnt_q   <= '0;
`ifdef INSTR_ENC_CHECK_EN
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
`ifdef INSTR_ENC_CHECK_EN
      err_q   <= err_d;
`endif
    end
  end

endmodule

// File: tb/tb_instr_encoder_writer.sv
// Randomised bench for instr_encoder_writer with a queue-based reference of expected writes.
`timescale 1ns/1ps
module tb_instr_encoder_writer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [9:0]  base_addr = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        in_last = 1'b0;
  logic [1:0]  in_fmt = '0;
  logic [4:0]  in_opcode = '0, in_rs = '0, in_rt = '0, in_rd = '0;
  logic [11:0] in_funct = '0;
  logic [16:0] in_imm = '0;
  logic [26:0] in_target = '0;
  logic        mem_wr_en;
  logic        mem_wr_ready = 1'b0;
  logic [9:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic        busy, done;
  logic [10:0] words_written;
`ifdef INSTR_ENC_CHECK_EN
  logic        err;
`endif

  always #5 clk = ~clk;

  instr_encoder_writer #(.ADDR_W(10), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
    .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last), .in_fmt(in_fmt),
    .in_opcode(in_opcode), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd),
    .in_funct(in_funct), .in_imm(in_imm), .in_target(in_target),
    .mem_wr_en(mem_wr_en), .mem_wr_ready(mem_wr_ready), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .busy(busy), .done(done),
`ifdef INSTR_ENC_CHECK_EN
    .err(err),
`endif
    .words_written(words_written)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference model: the ordered list of (address, word) writes the program must produce.
  typedef struct {
    logic [9:0]  a;
    logic [31:0] d;
  } exp_t;
  exp_t       exp_q[$];
  logic [9:0] mdl_base = '0;
  int         mdl_idx = 0;
  int         ready_mode = 0;  // 0: always ready, 1: never ready, 2: random

  function automatic logic [31:0] ref_word(input int fmt, input int op, input int rs, input int rt,
                                           input int rd, input int funct, input int imm, input int tgt);
    longint w;
    w = longint'(op) * (2**27);
    if (fmt == 1)      w = w + rs * (2**22) + rt * (2**17) + imm;
    else if (fmt == 2) w = w + tgt;
    else               w = w + rs * (2**22) + rt * (2**17) + rd * (2**12) + funct;
    return w[31:0];
  endfunction

  initial begin
    forever begin
      @(posedge clk); #1;
      case (ready_mode)
        0: mem_wr_ready = 1'b1;
        1: mem_wr_ready = 1'b0;
        default: mem_wr_ready = ($urandom_range(0, 1) == 1);
      endcase
    end
  end

  // Write monitor: each handshake must match the head of the expected list,
  // and a stalled request must hold address and data.
  logic        held = 1'b0;
  logic [9:0]  held_a;
  logic [31:0] held_d;
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      held = 1'b0;
    end else begin
      if (held) begin
        check_val("hold_wr_en", mem_wr_en, 1);
        check_val("hold_addr", mem_addr, held_a);
        check_val("hold_data", mem_wdata, held_d);
      end
      if (mem_wr_en && mem_wr_ready) begin
        if (exp_q.size() == 0) begin
          check_val("spurious_write", 1, 0);
        end else begin
          e = exp_q.pop_front();
          $display("write addr=0x%03h data=0x%08h (exp 0x%03h 0x%08h)", mem_addr, mem_wdata, e.a, e.d);
          check_val("wr_addr", mem_addr, e.a);
          check_val("wr_data", mem_wdata, e.d);
        end
      end
      held   = mem_wr_en && !mem_wr_ready;
      held_a = mem_addr;
      held_d = mem_wdata;
    end
  end

  // All driving tasks start and end at posedge+1.
  task automatic send_fields(input int fmt, input int op, input int rs, input int rt, input int rd,
                             input int funct, input int imm, input int tgt, input bit last);
    bit acc;
    exp_t e;
    in_valid = 1'b1; in_last = last; in_fmt = fmt[1:0];
    in_opcode = op[4:0]; in_rs = rs[4:0]; in_rt = rt[4:0]; in_rd = rd[4:0];
    in_funct = funct[11:0]; in_imm = imm[16:0]; in_target = tgt[26:0];
    acc = 1'b0;
    for (int i = 0; i < 300 && !acc; i++) begin
      @(negedge clk);
      if (in_ready) acc = 1'b1;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    if (!acc) begin
      check_val("accept_timeout", 0, 1);
    end else begin
`ifdef INSTR_ENC_CHECK_EN
      if (fmt != 3) begin
`else
      begin
`endif
        e.a = mdl_base + 10'(mdl_idx);
        e.d = ref_word(fmt, op, rs, rt, rd, funct, imm, tgt);
        exp_q.push_back(e);
        mdl_idx++;
      end
    end
  endtask

  task automatic send_rand(input int fmt, input bit last);
    send_fields(fmt, $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31),
                $urandom_range(0, 31), $urandom_range(0, 4095), $urandom_range(0, 131071),
                $urandom_range(0, 134217727), last);
  endtask

  task automatic start_prog(input logic [9:0] base);
    start = 1'b1;
    base_addr = base;
    @(posedge clk); #1;
    start = 1'b0;
    mdl_base = base;
    mdl_idx = 0;
    exp_q.delete();
    @(negedge clk);
    check_val("start_busy", busy, 1);
    check_val("start_count", words_written, 0);
    check_val("start_addr", mem_addr, base);
`ifdef INSTR_ENC_CHECK_EN
    check_val("start_err_clr", err, 0);
`endif
    @(posedge clk); #1;
  endtask

  task automatic wait_done();
    bit found;
    found = 1'b0;
    for (int i = 0; i < 2000 && !found; i++) begin
      @(negedge clk);
      if (done) found = 1'b1;
    end
    if (!found) begin
      check_val("done_timeout", 0, 1);
    end else begin
      check_val("done_count", words_written, mdl_idx);
      check_val("done_all_written", exp_q.size(), 0);
      check_val("done_busy", busy, 1);
      @(negedge clk);
      check_val("done_pulse", done, 0);
      check_val("idle_busy", busy, 0);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, fmax;
    repeat (2) @(negedge clk);
    check_val("rst_busy", busy, 0);
    check_val("rst_done", done, 0);
    check_val("rst_wr_en", mem_wr_en, 0);
    check_val("rst_in_ready", in_ready, 0);
    check_val("rst_addr", mem_addr, 0);
    check_val("rst_count", words_written, 0);
    check_val("rst_wdata", mem_wdata, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Single R-type word, also checks one-cycle accept-to-write latency.
    ready_mode = 0;
    start_prog(10'h010);
    send_fields(0, 0, 1, 2, 3, 'h020, 0, 0, 1'b1);
    @(negedge clk);
    check_val("latency_wr_en", mem_wr_en, 1);
    check_val("t1_addr", mem_addr, 10'h010);
    check_val("t1_data", mem_wdata, 32'h00443020);
    @(posedge clk); #1;
    wait_done();

    // J then I; a start pulse mid-program must be ignored.
    start_prog(10'h100);
    send_fields(2, 2, 0, 0, 0, 0, 0, 65, 1'b0);
    start = 1'b1; base_addr = 10'h200;
    @(posedge clk); #1;
    start = 1'b0;
    send_fields(1, 8, 0, 5, 0, 0, 'h1FFFF, 0, 1'b1);
    wait_done();

    // Back-pressure: four accepts fill the buffer, the fifth waits.
    ready_mode = 1;
    start_prog(10'h020);
    for (int k = 0; k < 4; k++) send_rand($urandom_range(0, 2), 1'b0);
    repeat (3) @(negedge clk);
    check_val("full_in_ready", in_ready, 0);
    check_val("full_wr_en", mem_wr_en, 1);
    check_val("full_addr", mem_addr, 10'h020);
    ready_mode = 0;
    @(posedge clk); #1;
    send_rand($urandom_range(0, 2), 1'b1);
    wait_done();

    // Address wrap at the top of memory; reserved format in the default build packs as R.
`ifdef INSTR_ENC_CHECK_EN
    fmax = 2;
`else
    fmax = 3;
`endif
    start_prog(10'h3FF);
    send_rand(fmax, 1'b0);
    send_rand(1, 1'b1);
    wait_done();

    // Reset mid-program with three words queued.
    ready_mode = 1;
    start_prog(10'h050);
    for (int k = 0; k < 3; k++) send_rand($urandom_range(0, 2), 1'b0);
    @(negedge clk); #2;
    rst_n = 1'b0;
    #1;
    check_val("mid_rst_wr_en", mem_wr_en, 0);
    check_val("mid_rst_busy", busy, 0);
    check_val("mid_rst_in_ready", in_ready, 0);
    exp_q.delete();
    @(negedge clk); #2;
    rst_n = 1'b1;
    ready_mode = 0;
    repeat (4) @(negedge clk);
    check_val("post_rst_wr_en", mem_wr_en, 0);
    check_val("post_rst_count", words_written, 0);
    @(posedge clk); #1;
    start_prog(10'h060);
    send_rand(0, 1'b0);
    send_rand(2, 1'b1);
    wait_done();

    // Random programs under random memory back-pressure.
    ready_mode = 2;
    for (int p = 0; p < 6; p++) begin
      start_prog(10'($urandom_range(0, 1023)));
      n = $urandom_range(1, 8);
      for (int k = 0; k < n; k++) begin
        send_rand($urandom_range(0, fmax), k == n - 1);
        repeat ($urandom_range(0, 2)) begin
          @(posedge clk); #1;
        end
      end
      wait_done();
    end

`ifdef INSTR_ENC_CHECK_EN
    // Reserved-format bundle is dropped and flags err until the next start.
    ready_mode = 0;
    start_prog(10'h080);
    send_rand(0, 1'b0);
    send_rand(3, 1'b0);
    send_rand(1, 1'b1);
    wait_done();
    check_val("err_set", err, 1);
    repeat (3) @(negedge clk);
    check_val("err_sticky", err, 1);
    @(posedge clk); #1;
    start_prog(10'h090);
    send_rand(2, 1'b0);
    send_rand(3, 1'b1);
    wait_done();
    check_val("err_last_rsv", err, 1);
`endif

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/instr_encoder_writer.md
Name: instr_encoder_writer

Overview:
- Counterpart to the instruction decoder: packs instruction fields into 32-bit words using the same big-endian [0:31] layout (opcode in bits [0:4]).
- Words are buffered in a small FIFO and streamed into instruction memory at consecutive word addresses.
- Used by the bench loader and the boot path to build programs for the decoder and fetch stage.

Parameters:
ADDR_W, 10, instruction-memory word-address width
FIFO_DEPTH, 4, encoded-word buffer depth (power of 2, >=2)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  1-cycle pulse in IDLE: load base_addr, enter RUN
base_addr  in  ADDR_W  first write address
in_valid  in  1  field bundle valid
in_ready  out  1  bundle accepted when in_valid&&in_ready
in_last  in  1  qualifies final bundle of program
in_fmt  in  2  0=R, 1=I, 2=J, 3=reserved
in_opcode  in  5  word bits [0:4]
in_rs  in  5  R/I bits [5:9]
in_rt  in  5  R/I bits [10:14]
in_rd  in  5  R bits [15:19]
in_funct  in  12  R bits [20:31]
in_imm  in  17  I bits [15:31]
in_target  in  27  J bits [5:31]
mem_wr_en  out  1  write request
mem_wr_ready  in  1  memory accepts write this cycle
mem_addr  out  ADDR_W  word address
mem_wdata  out  32  encoded word, [0:31]
busy  out  1  state != IDLE
done  out  1  1-cycle pulse, program fully written
words_written  out  ADDR_W+1  writes completed since start

Behaviour:
- Reset is asynchronous (active-low rst_n); all outputs are 0, the FIFO is empty, and the state is IDLE.
- States: IDLE, RUN, DRAIN, DONE.
  - IDLE: start -> RUN; mem_addr<=base_addr; words_written<=0. start is ignored in any other state.
  - RUN: in_ready = !fifo_full. An accept with in_last=1 -> DRAIN.
  - DRAIN: in_ready=0. When FIFO is empty and no write is pending -> DONE.
  - DONE: done=1 for one cycle -> IDLE.
- Packing is combinational from the fields; the word is pushed into the FIFO on accept. Unused bits for each format come from the format's own fields only.
  - fmt 3 packs as R-type.
- Latency: bundle accepted at edge N -> mem_wr_en=1 with that word at cycle N+1 (show-ahead FIFO, empty-bypass not required).
- mem_wr_en = !fifo_empty in RUN or DRAIN.
  - mem_wdata and mem_addr hold stable until mem_wr_en&&mem_wr_ready.
  - On that handshake: pop, mem_addr+1 (wraps modulo 2^ADDR_W, no flag), words_written+1 (saturates at all-ones).
- Push and pop in the same cycle are legal whenever the FIFO is not full. Full: in_ready=0, so no push. Empty: mem_wr_en=0.
- in_last accepted on an otherwise empty program (first bundle) is legal: one word is written, then DONE.
- rst_n asserted mid-operation: FIFO contents are discarded, no further writes occur, state -> IDLE.

Optional Feature:
- Macro INSTR_ENC_CHECK_EN.
- When defined:
  - Adds output err (1 bit, sticky until next start).
  - A bundle with in_fmt==3 is accepted but not pushed, and sets err.
  - If it carries in_last, DRAIN still follows.
- When undefined: no err port; fmt 3 packs as R-type.

Decomposition:
- Package instr_enc_pkg:
  - fmt codes FMT_R/FMT_I/FMT_J/FMT_RSV
  - state enum
  - field bit positions (OPC 0:4, RS 5:9, RT 10:14, RD 15:19, FUNCT 20:31, IMM 15:31, TGT 5:31)
  - pack function
- Sub-module instr_enc_fifo: synchronous FIFO (FIFO_DEPTH x 32), show-ahead, full/empty, async active-low reset.

Test Plan:
- start with base_addr=0x010; R bundle op=0, rs=1, rt=2, rd=3, funct=0x020, in_last=1 -> one write addr 0x010, data 0x00443020; done pulse; words_written=1.
- J op=2, target=65, then I op=8, rs=0, rt=5, imm=0x1FFFF (last) -> writes 0x10000041 @base, 0x400BFFFF @base+1; done after second handshake.
- mem_wr_ready held 0 while pushing 5 bundles -> in_ready drops after 4 accepts; releasing ready drains in order, addresses consecutive, no loss or duplication.
- base_addr=0x3FF with 2 words -> addresses 0x3FF then 0x000.
- rst_n low for 1 cycle with 3 words queued -> mem_wr_en=0 immediately, busy=0, a subsequent start writes only new words.
- INSTR_ENC_CHECK_EN defined, fmt=3 bundle between two valid ones -> 2 writes, err=1 until next start.
